stash_input_ctl: RTL and testbench

- Front-end stage that feeds Stash. It takes the raw board switches and two raw push-buttons, then synchronises and debounces them.
- It produces the single-cycle `sample_in_valid` and `next_sample` strobes, with `sample_in` aligned to its strobe.
- An optional auto-advance mode pulses `next_sample` periodically so stored samples can be browsed without button presses.

---
 rtl/btn_debounce.sv | 60 ++++++
 rtl/stash_input_ctl.sv | 99 +++++++++
 tb/tb_stash_input_ctl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/btn_debounce.sv
// btn_debounce
//   Conditions one raw, asynchronous push-button for use in the clk domain:
//   a 2-flop synchroniser, a debounce counter that must see DEBOUNCE_CYCLES
//   consecutive disagreeing samples before the stable level flips, and a
//   rising-edge detector on the stable level.
//
// Ports
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   raw    in   raw button level, asynchronous to clk
//   pulse  out  high for exactly one cycle after each accepted 0->1 transition
//               of the stable level (combinational from flops; the consumer
//               registers it)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_q1  <= raw;
      sync_q2  <= sync_q1;
      stable_q <= stable;
      if (sync_q2 != stable) begin
        // The DEBOUNCE_CYCLES-th consecutive disagreeing sample is accepted.
        if (cnt == CNT_LAST) begin
          stable <= sync_q2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Any agreeing sample restarts the run, rejecting short glitches.
        cnt <= '0;
      end
    end
  end

  assign pulse = stable & ~stable_q;

endmodule

// File: rtl/stash_input_ctl.sv
// stash_input_ctl
//   Front end for Stash. Synchronises the board switches and the auto-advance
//   switch, debounces the two push-buttons, and produces registered
//   one-cycle strobes: sample_in_valid (with sample_in captured on the same
//   edge) and next_sample (manual button or periodic auto-advance).
//
// Ports
//   clk              in   system clock
//   reset            in   asynchronous, active-high reset
//   sw[7:0]          in   raw slide switches, asynchronous
//   btn_sample       in   raw button: capture sw
//   btn_next         in   raw button: advance read pointer
//   auto_en          in   raw switch enabling auto-advance
//   sample_in[7:0]   out  captured switch value, held until next capture
//   sample_in_valid  out  one-cycle capture strobe
//   next_sample      out  one-cycle advance strobe (never with sample_in_valid)
module stash_input_ctl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       btn_sample,
  input  logic       btn_next,
  input  logic       auto_en,
  output logic [7:0] sample_in,
  output logic       sample_in_valid,
  output logic       next_sample
);

  localparam int AW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

  logic [7:0]    sw_q1;
  logic [7:0]    sw_q2;
  logic          auto_q1;
  logic          auto_q2;
  logic [AW-1:0] auto_cnt;

  logic          sample_pulse;
  logic          next_pulse;
  logic          auto_wrap;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_sample (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_sample),
    .pulse(sample_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_next (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_next),
    .pulse(next_pulse)
  );

  assign auto_wrap = auto_q2 && (auto_cnt == AUTO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_q1           <= '0;
      sw_q2           <= '0;
      auto_q1         <= 1'b0;
      auto_q2         <= 1'b0;
      auto_cnt        <= '0;
      sample_in       <= '0;
      sample_in_valid <= 1'b0;
      next_sample     <= 1'b0;
    end else begin
      sw_q1   <= sw;
      sw_q2   <= sw_q1;
      auto_q1 <= auto_en;
      auto_q2 <= auto_q1;

      // Capture wins; a coincident manual/auto advance is dropped, and
      // manual+auto together merge into a single strobe.
      sample_in_valid <= sample_pulse;
      next_sample     <= (next_pulse | auto_wrap) & ~sample_pulse;
      if (sample_pulse) begin
        sample_in <= sw_q2;
      end

      // Cleared on the edge that raises sample_in_valid so the auto period
      // restarts from the capture cycle.
      if (!auto_q2 || sample_pulse || auto_wrap) begin
        auto_cnt <= '0;
      end else begin
        auto_cnt <= auto_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stash_input_ctl.sv
module tb_stash_input_ctl;

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic       btn_sample;
  logic       btn_next;
  logic       auto_en;
  logic [7:0] sample_in;
  logic       sample_in_valid;
  logic       next_sample;

  int n_checks = 0;
  int n_fail   = 0;

  stash_input_ctl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sw             (sw),
    .btn_sample     (btn_sample),
    .btn_next       (btn_next),
    .auto_en        (auto_en),
    .sample_in      (sample_in),
    .sample_in_valid(sample_in_valid),
    .next_sample    (next_sample)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  sw;
    logic        bs;
    logic        bn;
    logic        ae;
    int unsigned reps;
    logic [7:0]  si;
    logic        v;
    logic        n;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] si, input logic v, input logic n);
    chk($sformatf("%s sample_in", tag), sample_in, si);
    chk($sformatf("%s sample_in_valid", tag), {7'b0, sample_in_valid}, {7'b0, v});
    chk($sformatf("%s next_sample", tag), {7'b0, next_sample}, {7'b0, n});
    chk($sformatf("%s exclusive", tag), {7'b0, sample_in_valid & next_sample}, 8'h00);
  endtask

  // One active edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int unsigned reps,
                     input logic [7:0] si, input logic v, input logic n);
    for (int unsigned k = 0; k < reps; k++) begin
      tick();
      expect_out($sformatf("%s[%0d]", tag, k), si, v, n);
    end
  endtask

  initial begin
    reset      = 1'b1;
    sw         = 8'h00;
    btn_sample = 1'b0;
    btn_next   = 1'b0;
    auto_en    = 1'b0;

    // Reset, then an interrupted press that must fully re-debounce.
    run("rst_hold", 3, 8'h00, 1'b0, 1'b0);
    reset      = 1'b0;
    sw         = 8'h11;
    btn_sample = 1'b1;
    run("rst_precount", 3, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    expect_out("rst_async", 8'h00, 1'b0, 1'b0);
    run("rst_mid", 2, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    run("rst_redb", 6, 8'h00, 1'b0, 1'b0);
    run("rst_pulse", 1, 8'h11, 1'b1, 1'b0);
    run("rst_after", 1, 8'h11, 1'b0, 1'b0);
    btn_sample = 1'b0;
    run("rst_release", 10, 8'h11, 1'b0, 1'b0);

    // Clean press, sw changes while held, release
    tbl.push_back('{8'hA5, 1'b1, 1'b0, 1'b0,  6, 8'h11, 1'b0, 1'b0});
    tbl.push_back('{8'hA5, 1'b1, 1'b0, 1'b0,  1, 8'hA5, 1'b1, 1'b0});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 13, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 10, 8'hA5, 1'b0, 1'b0});
    // Bouncing btn_next, then steady from tick 9 -> pulse on tick 15
    tbl.push_back('{8'hFF, 1'b0, 1'b1, 1'b0,  2, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b0,  2, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b1, 1'b0,  2, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b0,  2, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b1, 1'b0,  6, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b1, 1'b0,  1, 8'hA5, 1'b0, 1'b1});
    tbl.push_back('{8'hFF, 1'b0, 1'b1, 1'b0, 10, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 10, 8'hA5, 1'b0, 1'b0});
    // Auto-advance: 2 sync edges + 8-cycle period -> ticks 10, 18, 26
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b1,  9, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b1,  1, 8'hA5, 1'b0, 1'b1});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b1,  7, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b1,  1, 8'hA5, 1'b0, 1'b1});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b1,  7, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b1,  1, 8'hA5, 1'b0, 1'b1});
    // Capture mid-period restarts the period from the valid cycle
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 1'b1,  6, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 1'b1,  1, 8'h5A, 1'b1, 1'b0});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 1'b1,  7, 8'h5A, 1'b0, 1'b0});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 1'b1,  1, 8'h5A, 1'b0, 1'b1});
    tbl.push_back('{8'h5A, 1'b0, 1'b0, 1'b1,  7, 8'h5A, 1'b0, 1'b0});
    tbl.push_back('{8'h5A, 1'b0, 1'b0, 1'b1,  1, 8'h5A, 1'b0, 1'b1});
    // auto_en off: no pulses
    tbl.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 20, 8'h5A, 1'b0, 1'b0});
    // Sample and next together: capture wins, next dropped
    tbl.push_back('{8'h3C, 1'b1, 1'b1, 1'b0,  6, 8'h5A, 1'b0, 1'b0});
    tbl.push_back('{8'h3C, 1'b1, 1'b1, 1'b0,  1, 8'h3C, 1'b1, 1'b0});
    tbl.push_back('{8'h3C, 1'b1, 1'b1, 1'b0, 10, 8'h3C, 1'b0, 1'b0});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 10, 8'h3C, 1'b0, 1'b0});
    // Manual next lands on the auto wrap at tick 18; period continues to 26
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 1'b1,  9, 8'h3C, 1'b0, 1'b0});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 1'b1,  1, 8'h3C, 1'b0, 1'b1});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 1'b1,  1, 8'h3C, 1'b0, 1'b0});
    tbl.push_back('{8'h3C, 1'b0, 1'b1, 1'b1,  6, 8'h3C, 1'b0, 1'b0});
    tbl.push_back('{8'h3C, 1'b0, 1'b1, 1'b1,  1, 8'h3C, 1'b0, 1'b1});
    tbl.push_back('{8'h3C, 1'b0, 1'b1, 1'b1,  7, 8'h3C, 1'b0, 1'b0});
    tbl.push_back('{8'h3C, 1'b0, 1'b1, 1'b1,  1, 8'h3C, 1'b0, 1'b1});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 10, 8'h3C, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      sw         = tbl[i].sw;
      btn_sample = tbl[i].bs;
      btn_next   = tbl[i].bn;
      auto_en    = tbl[i].ae;
      run($sformatf("row%0d", i), tbl[i].reps, tbl[i].si, tbl[i].v, tbl[i].n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
